if_id_buf: RTL and testbench

IF_ID_BUF -- requirements
Module: if_id_buf

---
 rtl/if_id_buf_pkg.sv | 16 +
 rtl/if_id_buf_sync_fifo.sv | 55 +++++
 rtl/if_id_buf.sv | 73 +++++++
 tb/tb_if_id_buf.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_buf_pkg.sv
// Shared widths, chip-enable levels and buffer defaults for the fetch/decode buffer.
package if_id_buf_pkg;

  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam int          IfBufDepth  = 4;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } if_entry_t;

endpackage

// File: rtl/if_id_buf_sync_fifo.sv
// Synchronous FIFO with flush; push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int width = 64,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [width-1:0]         din,
  output logic [width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(depth));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; when full, the write slot equals the head being popped.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/if_id_buf.sv
// Fetch-to-decode buffer: captures the ROM address/data pair and queues it for decode.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int DEPTH = IfBufDepth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic                   ce_i,
  input  logic [InstBus-1:0]     inst_i,
  input  logic                   flush_i,
  input  logic                   id_ready_i,
  output logic                   id_valid_o,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic [InstBus-1:0]     id_inst_o,
  output logic                   stall_req_o,
  output logic                   ovf_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [InstAddrBus-1:0] r_pc_d;
  logic                   r_vld_d;
  logic                   r_ovf;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_count;
  if_entry_t              w_head;
  if_entry_t              w_tail;

  assign w_push = r_vld_d && !flush_i;
  assign w_pop  = !w_empty && id_ready_i;
  assign w_tail = '{pc: r_pc_d, inst: inst_i};

  sync_fifo #(
    .width ($bits(if_entry_t)),
    .depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (flush_i),
    .din   (w_tail),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_d  <= ZeroWord;
      r_vld_d <= ChipDisable;
      r_ovf   <= 1'b0;
    end else begin
      r_pc_d  <= pc_i;
      r_vld_d <= flush_i ? ChipDisable : (ce_i == ChipEnable);
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // Threshold leaves room for the two fetches already between pc stage and FIFO.
  assign stall_req_o = (w_count >= CW'(DEPTH - 2));
  assign id_valid_o  = !w_empty;
  assign id_pc_o     = w_empty ? ZeroWord : w_head.pc;
  assign id_inst_o   = w_empty ? ZeroWord : w_head.inst;
  assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_if_id_buf.sv
// Randomized bench for if_id_buf against a queue-based model of the fetch buffer.
module tb_if_id_buf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        ce_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic        flush_i = 1'b0;
  logic        id_ready_i = 1'b0;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        stall_req_o;
  logic        ovf_o;
  logic [66:0] w_obs;

  int total = 0;
  int bad   = 0;

  logic [63:0] q[$];
  logic        m_vld_d = 1'b0;
  logic [31:0] m_pc_d  = '0;
  logic        m_ovf   = 1'b0;

  if_id_buf #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc_i),
    .ce_i        (ce_i),
    .inst_i      (inst_i),
    .flush_i     (flush_i),
    .id_ready_i  (id_ready_i),
    .id_valid_o  (id_valid_o),
    .id_pc_o     (id_pc_o),
    .id_inst_o   (id_inst_o),
    .stall_req_o (stall_req_o),
    .ovf_o       (ovf_o)
  );

  assign w_obs = {id_valid_o, id_pc_o, id_inst_o, stall_req_o, ovf_o};

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a + 32'hA0;
  endfunction

  function automatic logic [66:0] exp_out();
    logic [63:0] h;
    h = (q.size() != 0) ? q[0] : 64'd0;
    return {q.size() != 0, h, q.size() >= DEPTH - 2, m_ovf};
  endfunction

  // Inputs change at the falling edge; the ROM answers for the address captured last edge.
  task automatic drive(input logic r, input logic c, input logic f, input logic rd,
                       input logic [31:0] pc);
    rst = r; ce_i = c; flush_i = f; id_ready_i = rd; pc_i = pc;
    inst_i = rom(m_pc_d);
    #1;
  endtask

  task automatic tick();
    bit pop, push;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_vld_d = 1'b0; m_pc_d = '0; m_ovf = 1'b0;
    end else begin
      pop  = (q.size() != 0) && id_ready_i;
      push = m_vld_d && !flush_i;
      if (flush_i) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          if (q.size() < DEPTH) q.push_back({m_pc_d, inst_i});
          else m_ovf = 1'b1;
        end
      end
      m_vld_d = flush_i ? 1'b0 : ce_i;
      m_pc_d  = pc_i;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 1, 32'h55);
    tick();
    tick();
    drive(0, 0, 0, 0, 0);
    total++;
    if (w_obs !== exp_out() || exp_out() !== 67'd0) begin
      bad++; $display("FAIL reset got=%h exp=%h", w_obs, exp_out());
    end
    tick();
  endtask

  task automatic test_run();
    int first = -1;
    for (int i = 0; i < 6; i++) begin
      drive(0, i < 3, 0, 1, i);
      if (id_valid_o === 1'b1 && first < 0) first = i;
      total++;
      if (w_obs !== exp_out()) begin
        bad++; $display("FAIL run c%0d got=%h exp=%h", i, w_obs, exp_out());
      end
      tick();
    end
    total++;
    if (first !== 2) begin
      bad++; $display("FAIL run_latency got=%0d exp=2", first);
    end
  endtask

  task automatic test_backpressure();
    int exp_pops, pops = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, !(q.size() >= DEPTH - 2), 0, 0, 32'h100 + i);
      total++;
      if (w_obs !== exp_out()) begin
        bad++; $display("FAIL backpressure c%0d got=%h exp=%h", i, w_obs, exp_out());
      end
      tick();
    end
    exp_pops = q.size();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1, 0);
      if (id_valid_o === 1'b1) pops++;
      total++;
      if (w_obs !== exp_out()) begin
        bad++; $display("FAIL bp_drain c%0d got=%h exp=%h", i, w_obs, exp_out());
      end
      tick();
    end
    total++;
    if (pops !== exp_pops) begin
      bad++; $display("FAIL bp_pops got=%0d exp=%0d", pops, exp_pops);
    end
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 7; i++) begin
      drive(0, i < 4, 0, 0, base + i);
      tick();
    end
  endtask

  task automatic test_full_pop();
    fill(32'h200);
    for (int i = 0; i < 12; i++) begin
      drive(0, i == 0, 0, (i == 1) || (i >= 4), 32'h2F0 + i);
      total++;
      if (w_obs !== exp_out()) begin
        bad++; $display("FAIL full_pop c%0d got=%h exp=%h", i, w_obs, exp_out());
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    fill(32'h300);
    for (int i = 0; i < 6; i++) begin
      drive(0, i == 0, i == 4, 0, 32'h3F0 + i);
      total++;
      if (w_obs !== exp_out()) begin
        bad++; $display("FAIL overflow c%0d got=%h exp=%h", i, w_obs, exp_out());
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    total++;
    if (ovf_o !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf_o);
    end
    tick();
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    total++;
    if (w_obs !== exp_out() || ovf_o !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%h exp=%h", w_obs, exp_out());
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 32'h400 + i);
      tick();
    end
    drive(0, 1, 1, 1, 32'h404);
    total++;
    if (w_obs !== exp_out()) begin
      bad++; $display("FAIL pre_flush got=%h exp=%h", w_obs, exp_out());
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0);
      total++;
      if (w_obs !== exp_out() || id_valid_o !== 1'b0) begin
        bad++; $display("FAIL flush c%0d got=%h exp=%h", i, w_obs, exp_out());
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] base;
    base = $urandom;
    for (int i = 0; i < 14; i++) begin
      drive(0, i < 10, 0, 1, base + i);
      total++;
      if (w_obs !== exp_out()) begin
        bad++; $display("FAIL wrap c%0d got=%h exp=%h", i, w_obs, exp_out());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, $urandom);
      total++;
      if (w_obs !== exp_out()) begin
        bad++; $display("FAIL random c%0d got=%h exp=%h", i, w_obs, exp_out());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_backpressure();
    test_full_pop();
    test_overflow();
    test_flush();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
